// File: rtl/perf_trace_monitor_if.sv
// Trace record stream between the monitor (master) and the debug-port drain (slave).
// trace_data layout: {type[1:0], addr_or_reg[15:0], data[15:0]}.
interface perf_trace_monitor_if;
   logic        trace_valid;
   logic [33:0] trace_data;
   logic        trace_rdy;

   modport master (output trace_valid, output trace_data, input trace_rdy);
   modport slave  (input trace_valid, input trace_data, output trace_rdy);
endinterface

// File: rtl/perf_trace_monitor.sv
// Retire/event monitor for the pipelined core.
// Counts cycles, retired instructions and generic events with saturating counters, and
// streams one trace record per cycle (HALT > STORE > LOAD > REG) through a small FIFO.
// The monitor freezes after a retired halt; only rst/clr return it to RUN, while the FIFO
// keeps draining in the meantime.
module perf_trace_monitor #(
   parameter int NUM_EVT     = 6,
   parameter int CNT_W       = 32,
   parameter int TRACE_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     halt,
   input  logic                     reg_wrt,
   input  logic [2:0]               wr_reg,
   input  logic [15:0]              wr_data,
   input  logic                     mem_rd,
   input  logic                     mem_wrt,
   input  logic [15:0]              mem_addr,
   input  logic [15:0]              mem_data,
   input  logic [NUM_EVT-1:0]       evt,
   perf_trace_monitor_if.master     trace,
   output logic                     trace_ovf,
   output logic                     halted,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [CNT_W-1:0]         inst_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);

   localparam int AW = $clog2(TRACE_DEPTH);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      REC_REG   = 2'd0,
      REC_LOAD  = 2'd1,
      REC_STORE = 2'd2,
      REC_HALT  = 2'd3
   } rec_type_t;

   // Add a small increment and clamp at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                                input logic [2:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, val} + (CNT_W+1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   state_t                        state_q, state_d;
   logic                          sync_clr;
   logic                          running;
   logic [CNT_W-1:0]              cycle_next;
   logic [15:0]                   halt_stamp;
   logic [2:0]                    cand_n;
   logic [2:0]                    drop_inc;
   logic [33:0]                   rec;
   logic                          have_rec;
   logic                          push;
   logic                          pop;
   logic                          full;
   logic [33:0]                   mem [TRACE_DEPTH];
   logic [AW-1:0]                 rd_ptr_q, wr_ptr_q, rd_ptr_d;
   logic [AW:0]                   count_q, count_d;
   logic [33:0]                   head_d;
   logic [NUM_EVT-1:0][CNT_W-1:0] evt_q;

   assign sync_clr   = rst | clr;
   assign running    = (state_q == ST_RUN);
   assign halted     = (state_q == ST_HALTED);
   assign cycle_next = sat_add(cycle_cnt, 3'd1);
   // The HALT record carries the cycle count including the halt cycle itself.
   assign halt_stamp = 16'(cycle_next);
   assign evt_cnt    = evt_q;

   // Next state: a retired halt freezes the monitor; only rst/clr bring it back.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch can be inferred.
      state_d = state_q;
      if (state_q == ST_RUN && halt) state_d = ST_HALTED;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (sync_clr) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   // Select the one record to push and count every candidate that cannot be stored.
   always_comb begin
      cand_n = 3'd0;
      rec    = '0;
      if (running) begin
         cand_n = 3'(halt) + 3'(mem_wrt) + 3'(mem_rd) + 3'(reg_wrt);
         if (halt)         rec = {REC_HALT, 16'h0000, halt_stamp};
         else if (mem_wrt) rec = {REC_STORE, mem_addr, mem_data};
         else if (mem_rd)  rec = {REC_LOAD, mem_addr, mem_data};
         else if (reg_wrt) rec = {REC_REG, 13'd0, wr_reg, wr_data};
      end
      have_rec = (cand_n != 3'd0);
      pop      = trace.trace_valid & trace.trace_rdy;
      full     = (count_q == (AW+1)'(TRACE_DEPTH));
      // A full FIFO still accepts the winner when its head leaves in the same cycle.
      push     = have_rec & (~full | pop);
      drop_inc = 3'd0;
      if (have_rec) drop_inc = push ? cand_n - 3'd1 : cand_n;
   end

   // Next FIFO pointers/occupancy and the record that will sit at the head next cycle.
   always_comb begin
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      head_d   = '0;
      // The slot at the new head is only written this cycle when the FIFO was about to be empty.
      if (count_d != '0) head_d = (push && (wr_ptr_q == rd_ptr_d)) ? rec : mem[rd_ptr_d];
   end

   // Trace storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the occupancy counter alone decides which entries are live.
      if (push) mem[wr_ptr_q] <= rec;
   end

   // FIFO control with registered head outputs.
   always_ff @(posedge clk) begin
      if (sync_clr) begin
         rd_ptr_q          <= '0;
         wr_ptr_q          <= '0;
         count_q           <= '0;
         trace.trace_valid <= 1'b0;
         trace.trace_data  <= '0;
      end else begin
         rd_ptr_q          <= rd_ptr_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         count_q           <= count_d;
         trace.trace_valid <= (count_d != '0);
         trace.trace_data  <= head_d;
      end
   end

   // Saturating counters and sticky overflow; everything holds while halted.
   always_ff @(posedge clk) begin
      if (sync_clr) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
         drop_cnt  <= '0;
         trace_ovf <= 1'b0;
         evt_q     <= '0;
      end else if (running) begin
         cycle_cnt <= cycle_next;
         if (halt | reg_wrt | mem_wrt) inst_cnt <= sat_add(inst_cnt, 3'd1);
         drop_cnt <= sat_add(drop_cnt, drop_inc);
         if (drop_inc != 3'd0) trace_ovf <= 1'b1;
         for (int i = 0; i < NUM_EVT; i++) begin
            if (evt[i]) evt_q[i] <= sat_add(evt_q[i], 3'd1);
         end
      end
   end

endmodule

// File: tb/tb_perf_trace_monitor.sv
// Bench for perf_trace_monitor: two instances (32-bit and 4-bit counters) share one stimulus
// stream and are checked every cycle against a queue-based reference model, with directed
// scenarios pinning literal values.
module tb_perf_trace_monitor;
   localparam int NUM_EVT = 6;
   localparam int DEPTH   = 8;
   localparam int WA      = 32;
   localparam int WB      = 4;

   logic               clk = 1'b0;
   logic               rst, clr, halt, reg_wrt, mem_rd, mem_wrt, rdy;
   logic [2:0]         wr_reg;
   logic [15:0]        wr_data, mem_addr, mem_data;
   logic [NUM_EVT-1:0] evt;

   logic                  ovf_a, halted_a, ovf_b, halted_b;
   logic [WA-1:0]         cyc_a, inst_a, drop_a;
   logic [WB-1:0]         cyc_b, inst_b, drop_b;
   logic [NUM_EVT*WA-1:0] evt_a;
   logic [NUM_EVT*WB-1:0] evt_b;

   always #5 clk = ~clk;

   perf_trace_monitor_if tif_a ();
   perf_trace_monitor_if tif_b ();
   assign tif_a.trace_rdy = rdy;
   assign tif_b.trace_rdy = rdy;

   perf_trace_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(WA), .TRACE_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .halt(halt), .reg_wrt(reg_wrt), .wr_reg(wr_reg),
      .wr_data(wr_data), .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
      .mem_data(mem_data), .evt(evt), .trace(tif_a), .trace_ovf(ovf_a), .halted(halted_a),
      .cycle_cnt(cyc_a), .inst_cnt(inst_a), .drop_cnt(drop_a), .evt_cnt(evt_a));

   perf_trace_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(WB), .TRACE_DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .halt(halt), .reg_wrt(reg_wrt), .wr_reg(wr_reg),
      .wr_data(wr_data), .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
      .mem_data(mem_data), .evt(evt), .trace(tif_b), .trace_ovf(ovf_b), .halted(halted_b),
      .cycle_cnt(cyc_b), .inst_cnt(inst_b), .drop_cnt(drop_b), .evt_cnt(evt_b));

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]  typ;
      logic [15:0] a;
      logic [15:0] d;
      longint      stamp;
   } rec_t;

   rec_t   mq[$];
   rec_t   cands[$];
   longint m_cyc, m_inst, m_drop;
   longint m_evt[NUM_EVT];
   bit     m_halted, m_ovf, m_pop, live;

   int n_cmp = 0;
   int n_bad = 0;
   logic [33:0] cap[$];

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [33:0] exp_rec(input rec_t r, input int w);
      if (r.typ == 2'd3) return {2'd3, 16'h0000, 16'(sat(r.stamp, w))};
      return {r.typ, r.a, r.d};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update from the inputs present at each rising edge.
   always @(posedge clk) begin
      live = 1'b1;
      if (rst || clr) begin
         m_cyc = 0; m_inst = 0; m_drop = 0;
         for (int i = 0; i < NUM_EVT; i++) m_evt[i] = 0;
         m_halted = 1'b0; m_ovf = 1'b0;
         mq.delete();
      end else begin
         m_pop = (mq.size() != 0) && rdy;
         cands.delete();
         if (!m_halted) begin
            m_cyc++;
            if (halt || reg_wrt || mem_wrt) m_inst++;
            for (int i = 0; i < NUM_EVT; i++) if (evt[i]) m_evt[i]++;
            if (halt)    cands.push_back('{2'd3, 16'h0000, 16'h0000, m_cyc});
            if (mem_wrt) cands.push_back('{2'd2, mem_addr, mem_data, 0});
            if (mem_rd)  cands.push_back('{2'd1, mem_addr, mem_data, 0});
            if (reg_wrt) cands.push_back('{2'd0, {13'd0, wr_reg}, wr_data, 0});
            if (cands.size() > 1) begin
               m_drop += cands.size() - 1;
               m_ovf = 1'b1;
            end
            if (halt) m_halted = 1'b1;
         end
         if (m_pop) void'(mq.pop_front());
         if (cands.size() != 0) begin
            if (mq.size() < DEPTH) mq.push_back(cands[0]);
            else begin
               m_drop++;
               m_ovf = 1'b1;
            end
         end
      end
   end

   // Compare every output of both instances against the model on the falling edge.
   always @(negedge clk) begin
      if (live) begin
         check("valid_a", tif_a.trace_valid, mq.size() != 0);
         check("valid_b", tif_b.trace_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            check("data_a", tif_a.trace_data, exp_rec(mq[0], WA));
            check("data_b", tif_b.trace_data, exp_rec(mq[0], WB));
         end
         check("cycle_a", cyc_a, sat(m_cyc, WA));
         check("cycle_b", cyc_b, sat(m_cyc, WB));
         check("inst_a", inst_a, sat(m_inst, WA));
         check("inst_b", inst_b, sat(m_inst, WB));
         check("drop_a", drop_a, sat(m_drop, WA));
         check("drop_b", drop_b, sat(m_drop, WB));
         check("ovf_a", ovf_a, m_ovf);
         check("ovf_b", ovf_b, m_ovf);
         check("halted_a", halted_a, m_halted);
         check("halted_b", halted_b, m_halted);
         for (int i = 0; i < NUM_EVT; i++) begin
            check($sformatf("evt_a[%0d]", i), evt_a[i*WA +: WA], sat(m_evt[i], WA));
            check($sformatf("evt_b[%0d]", i), evt_b[i*WB +: WB], sat(m_evt[i], WB));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      halt = 1'b0; reg_wrt = 1'b0; mem_rd = 1'b0; mem_wrt = 1'b0; evt = '0;
      wr_reg = '0; wr_data = '0; mem_addr = '0; mem_data = '0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   // Collect records popped from instance A until 'want' are seen or the budget runs out.
   task automatic drain(input int want, input int budget);
      for (int k = 0; k < budget && cap.size() < want; k++) begin
         if (tif_a.trace_valid && rdy) cap.push_back(tif_a.trace_data);
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; clr = 1'b0; rdy = 1'b0;
      idle();
      step(); step();
      check("rst_valid", tif_a.trace_valid, 1'b0);
      check("rst_data", tif_a.trace_data, 34'd0);
      check("rst_cycle", cyc_a, 0);
      check("rst_halted", halted_a, 1'b0);
      check("rst_ovf", ovf_a, 1'b0);

      // 1) 10 idle cycles, 3 register writes, halt.
      rst = 1'b0;
      repeat (10) step();
      for (int i = 1; i <= 3; i++) begin
         reg_wrt = 1'b1; wr_reg = 3'(i); wr_data = 16'h1000 + 16'(i);
         step();
      end
      idle();
      halt = 1'b1;
      step();
      idle();
      check("t1_cycle", cyc_a, 14);
      check("t1_cycle_b", cyc_b, 14);
      check("t1_inst", inst_a, 4);
      check("t1_halted", halted_a, 1'b1);
      check("t1_model_cycle", m_cyc, 14);
      rdy = 1'b1;
      cap.delete();
      drain(4, 20);
      check("t1_nrec", cap.size(), 4);
      if (cap.size() == 4) begin
         check("t1_rec0", cap[0], {2'd0, 13'd0, 3'd1, 16'h1001});
         check("t1_rec2", cap[2], {2'd0, 13'd0, 3'd3, 16'h1003});
         check("t1_halt_rec", cap[3], {2'd3, 16'h0000, 16'd14});
      end

      // 2) Register write and store in the same cycle: STORE wins, REG dropped.
      rdy = 1'b0;
      do_clr();
      reg_wrt = 1'b1; wr_reg = 3'd3; wr_data = 16'hBEEF;
      mem_wrt = 1'b1; mem_addr = 16'h0040; mem_data = 16'h1234;
      step();
      idle();
      check("t2_drop", drop_a, 1);
      check("t2_ovf", ovf_a, 1'b1);
      check("t2_inst", inst_a, 1);
      check("t2_head", tif_a.trace_data, {2'd2, 16'h0040, 16'h1234});

      // 3) Ten loads into a stalled 8-deep FIFO.
      do_clr();
      for (int i = 0; i < 10; i++) begin
         mem_rd = 1'b1; mem_addr = 16'h0100 + 16'(i); mem_data = 16'hA000 + 16'(i);
         step();
      end
      idle();
      check("t3_drop", drop_a, 2);
      check("t3_inst", inst_a, 0);
      check("t3_cycle", cyc_a, 10);
      check("t3_head", tif_a.trace_data, {2'd1, 16'h0100, 16'hA000});

      // 4) Full FIFO with push and pop in the same cycle, then prove it is still full.
      cap.delete();
      rdy = 1'b1;
      mem_rd = 1'b1; mem_addr = 16'h01FF; mem_data = 16'hBBBB;
      if (tif_a.trace_valid) cap.push_back(tif_a.trace_data);
      step();
      idle();
      check("t4_drop_same", drop_a, 2);
      rdy = 1'b0;
      mem_rd = 1'b1; mem_addr = 16'h02FF; mem_data = 16'hCCCC;
      step();
      idle();
      check("t4_still_full", drop_a, 3);
      rdy = 1'b1;
      drain(9, 30);
      check("t4_nrec", cap.size(), 9);
      if (cap.size() == 9) begin
         check("t4_first", cap[0], {2'd1, 16'h0100, 16'hA000});
         check("t4_eighth", cap[7], {2'd1, 16'h0107, 16'hA007});
         check("t4_last", cap[8], {2'd1, 16'h01FF, 16'hBBBB});
      end

      // 5) Saturation with 4-bit counters, then clear.
      rdy = 1'b0;
      do_clr();
      evt = 6'b000001;
      repeat (20) step();
      idle();
      check("t5_evt_b", evt_b[0 +: WB], 4'hF);
      check("t5_evt_a", evt_a[0 +: WA], 20);
      check("t5_cycle_b", cyc_b, 4'hF);
      halt = 1'b1;
      step();
      idle();
      check("t5_halted", halted_b, 1'b1);
      do_clr();
      check("t5_clr_cycle", cyc_a, 0);
      check("t5_clr_evt", evt_b[0 +: WB], 0);
      check("t5_clr_inst", inst_b, 0);
      check("t5_clr_halted", halted_a, 1'b0);
      check("t5_clr_valid", tif_a.trace_valid, 1'b0);

      // 6) Strobes ignored while halted; rst in the middle of a drain.
      for (int i = 1; i <= 3; i++) begin
         reg_wrt = 1'b1; wr_reg = 3'(i); wr_data = 16'h2000 + 16'(i);
         step();
      end
      idle();
      halt = 1'b1;
      step();
      repeat (5) begin
         halt = 1'b1; reg_wrt = 1'b1; mem_wrt = 1'b1; mem_rd = 1'b1; evt = '1;
         step();
      end
      idle();
      check("t6_cycle", cyc_a, 4);
      check("t6_inst", inst_a, 4);
      check("t6_drop", drop_a, 0);
      check("t6_evt5", evt_a[5*WA +: WA], 0);
      rdy = 1'b1;
      step();
      check("t6_head", tif_a.trace_data, {2'd0, 13'd0, 3'd2, 16'h2002});
      rst = 1'b1;
      step();
      check("t6_rst_valid", tif_a.trace_valid, 1'b0);
      check("t6_rst_data", tif_a.trace_data, 34'd0);
      rst = 1'b0;

      // Randomised traffic checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 599) == 0);
         clr      = ($urandom_range(0, 119) == 0);
         halt     = ($urandom_range(0, 149) == 0);
         reg_wrt  = ($urandom_range(0, 2) == 0);
         mem_rd   = ($urandom_range(0, 4) == 0);
         mem_wrt  = ($urandom_range(0, 5) == 0);
         wr_reg   = 3'($urandom);
         wr_data  = 16'($urandom);
         mem_addr = 16'($urandom);
         mem_data = 16'($urandom);
         evt      = NUM_EVT'($urandom);
         rdy      = ($urandom_range(0, 9) < (((c % 400) < 200) ? 3 : 8));
         step();
      end
      rst = 1'b0; clr = 1'b0; rdy = 1'b1;
      idle();
      repeat (12) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
